// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 core blocks.
package ej32_pkg;

    localparam int         EJ32_ASZ = 17;
    localparam logic [7:0] NOP      = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FLUSH
    } fu_state_t;

endpackage

// File: rtl/ej32_bfifo.sv
// Byte FIFO for the fetch unit: 0..4 bytes pushed per cycle, one byte popped.
module ej32_bfifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [2:0]             push_n,
    input  logic [3:0][7:0]        push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic [7:0]             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW-1:0] widx [4];
    logic [CW-1:0] count_nxt;
    logic          pop_ok;

    assign empty     = (count == '0);
    assign head      = mem[rptr];
    assign pop_ok    = pop && !empty;
    assign count_nxt = count + CW'(push_n) - CW'(pop_ok);

    always_comb begin
        for (int i = 0; i < 4; i++) widx[i] = wptr + AW'(i);
    end

    // NOTE: the byte storage has no reset; count/pointers gate every read, so
    // stale contents are never visible and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!clear && (3'(i) < push_n)) mem[widx[i]] <= push_data[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else if (clear) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            count <= count_nxt;
            wptr  <= wptr + AW'(push_n);
            rptr  <= rptr + AW'(pop_ok);
        end
    end

    // The fetch threshold must keep a full word of room; anything else is a bug upstream.
    always_ff @(posedge clk) begin
        if (rst && !clear) assert (count_nxt <= CW'(DEPTH));
    end

endmodule

// File: rtl/ej32_fu.sv
// eJ32 instruction fetch unit: PC, word prefetch into a byte FIFO, branch redirect.
module ej32_fu
    import ej32_pkg::*;
#(
    parameter int             ASZ   = EJ32_ASZ,
    parameter logic [ASZ-1:0] COLD  = '0,
    parameter int             DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_req,
    output logic [ASZ-1:0] mem_addr,
    input  logic           mem_ack,
    input  logic [31:0]    mem_rdata,
    input  logic           p_inc,
    input  logic           br_go,
    input  logic [ASZ-1:0] br_addr,
    output logic [7:0]     data,
    output logic           data_vld,
    output logic [ASZ-1:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fu_state_t       state, state_nxt;
    logic [ASZ-1:0]  fa, fa_nxt, addr_nxt;
    logic            req_nxt;
    logic [CW-1:0]   count, free_after;
    logic            empty, pop, room;
    logic [7:0]      head;
    logic [2:0]      push_n;
    logic [3:0][7:0] push_data;
    logic [31:0]     shifted;

    // A redirect wins over a pop in the same cycle.
    assign pop        = p_inc && !empty && !br_go;
    assign free_after = CW'(DEPTH) - count + CW'(pop);
    assign room       = (free_after >= CW'(4));
    assign data       = empty ? NOP : head;
    assign data_vld   = !empty;

    // Left-justify the word so the first wanted byte sits in push_data[0].
    assign shifted = mem_rdata << {fa[1:0], 3'b000};

    always_comb begin
        push_n = 3'd0;
        for (int i = 0; i < 4; i++) push_data[i] = shifted[31-8*i -: 8];
        if (state == BUSY && mem_ack && !br_go) push_n = 3'd4 - {1'b0, fa[1:0]};
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        fa_nxt    = fa;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        unique case (state)
            IDLE: begin
                if (br_go) begin
                    state_nxt = BUSY;
                    req_nxt   = 1'b1;
                    addr_nxt  = {br_addr[ASZ-1:2], 2'b00};
                end else if (room) begin
                    state_nxt = BUSY;
                    req_nxt   = 1'b1;
                    addr_nxt  = {fa[ASZ-1:2], 2'b00};
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    if (!br_go) fa_nxt = (fa | ASZ'(3)) + ASZ'(1);
                end else if (br_go) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (br_go) fa_nxt = br_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fa       <= COLD;
            pc       <= COLD;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            fa       <= fa_nxt;
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            if (br_go)    pc <= br_addr;
            else if (pop) pc <= pc + ASZ'(1);
        end
    end

    ej32_bfifo #(
        .DEPTH(DEPTH)
    ) u_bfifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (br_go),
        .push_n   (push_n),
        .push_data(push_data),
        .pop      (pop),
        .count    (count),
        .empty    (empty),
        .head     (head)
    );

endmodule

// File: tb/tb_ej32_fu.sv
// Directed bench for ej32_fu: cold start, redirect, flush, fill, empty, reset abort.
module tb_ej32_fu;

    localparam int ASZ = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_req;
    logic [ASZ-1:0] mem_addr;
    logic           mem_ack;
    logic [31:0]    mem_rdata;
    logic           p_inc;
    logic           br_go;
    logic [ASZ-1:0] br_addr;
    logic [7:0]     data;
    logic           data_vld;
    logic [ASZ-1:0] pc;

    int checks   = 0;
    int failures = 0;

    int lat        = 1;
    bit mem_auto   = 1'b1;
    bit inject_ack = 1'b0;
    int mem_cnt;

    logic [7:0]     pop_data [$];
    logic [ASZ-1:0] pop_pc   [$];
    logic [ASZ-1:0] ack_addr [$];

    ej32_fu #(
        .ASZ  (ASZ),
        .COLD (17'h10),
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .p_inc    (p_inc),
        .br_go    (br_go),
        .br_addr  (br_addr),
        .data     (data),
        .data_vld (data_vld),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ASZ-1:0] a);
        case (a)
            17'h10:  return 32'h11223344;
            17'h14:  return 32'h55667788;
            17'h20:  return 32'hAABBCCDD;
            17'h24:  return 32'h01020304;
            17'h30:  return 32'hC0C1C2C3;
            17'h40:  return 32'h40414243;
            17'h44:  return 32'h44454647;
            17'h50:  return 32'h50515253;
            17'h54:  return 32'h54555657;
            17'h58:  return 32'h58595A5B;
            17'h5C:  return 32'h5C5D5E5F;
            default: return 32'hF0F1F2F3;
        endcase
    endfunction

    // Memory: ack 'lat' cycles after the cycle req is first seen, driven at negedge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_cnt   = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end else if (inject_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hEEEEEEEE;
            end else if (mem_auto && mem_req) begin
                mem_cnt++;
                if (mem_cnt > lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Record consumed bytes and acknowledged fetch addresses.
    always @(negedge clk) begin
        #1;
        if (rst && p_inc && data_vld && !br_go) begin
            pop_data.push_back(data);
            pop_pc.push_back(pc);
        end
        if (rst && mem_req && mem_ack) ack_addr.push_back(mem_addr);
    end

    task automatic wait_pops(input int base, input int n, input string tag);
        int budget = 200;
        while (pop_data.size() < base + n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, pop_data.size() - base, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb, ab;
        rst     = 1'b0;
        p_inc   = 1'b0;
        br_go   = 1'b0;
        br_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pc", pc, 17'h10);
        check("rst_data", data, 8'h00);
        check("rst_vld", data_vld, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 17'h0);

        // Cold start streaming from 0x10
        rst   = 1'b1;
        p_inc = 1'b1;
        pb    = pop_data.size();
        ab    = ack_addr.size();
        wait_pops(pb, 8, "t1");
        for (int k = 0; k < 8; k++) begin
            check("t1_data", pop_data[pb+k], 8'(8'h11 * (k + 1)));
            check("t1_pc", pop_pc[pb+k], 17'h10 + k);
        end
        check("t1_addr0", ack_addr[ab], 17'h10);
        check("t1_addr1", ack_addr[ab+1], 17'h14);

        // Unaligned redirect from IDLE, with latency
        p_inc = 1'b0;
        repeat (20) @(negedge clk);
        br_go   = 1'b1;
        br_addr = 17'h21;
        @(negedge clk);
        br_go = 1'b0;
        check("t2_req_c1", mem_req, 1'b1);
        check("t2_addr_c1", mem_addr, 17'h20);
        check("t2_vld_c1", data_vld, 1'b0);
        @(negedge clk);
        check("t2_vld_c2", data_vld, 1'b0);
        @(negedge clk);
        check("t2_vld_c3", data_vld, 1'b1);
        check("t2_data_c3", data, 8'hBB);
        check("t2_pc_c3", pc, 17'h21);
        pb    = pop_data.size();
        p_inc = 1'b1;
        wait_pops(pb, 4, "t2");
        check("t2_d0", pop_data[pb],   8'hBB);
        check("t2_d1", pop_data[pb+1], 8'hCC);
        check("t2_d2", pop_data[pb+2], 8'hDD);
        check("t2_d3", pop_data[pb+3], 8'h01);
        check("t2_pc3", pop_pc[pb+3], 17'h24);

        // Redirect while BUSY with slow memory -> FLUSH
        p_inc = 1'b0;
        repeat (20) @(negedge clk);
        lat = 3;
        @(negedge clk);
        br_go   = 1'b1;
        br_addr = 17'h30;
        @(negedge clk);
        br_go = 1'b0;
        @(negedge clk);
        br_go   = 1'b1;
        br_addr = 17'h40;
        p_inc   = 1'b1;
        pb      = pop_data.size();
        ab      = ack_addr.size();
        @(negedge clk);
        br_go = 1'b0;
        check("t3_req_hold", mem_req, 1'b1);
        check("t3_addr_hold", mem_addr, 17'h30);
        check("t3_vld", data_vld, 1'b0);
        wait_pops(pb, 4, "t3");
        for (int k = 0; k < 4; k++) begin
            check("t3_data", pop_data[pb+k], 8'h40 + k);
            check("t3_pc", pop_pc[pb+k], 17'h40 + k);
        end
        check("t3_ack0", ack_addr[ab], 17'h30);
        check("t3_ack1", ack_addr[ab+1], 17'h40);

        // Fill to DEPTH with no consumer
        lat   = 1;
        p_inc = 1'b0;
        repeat (30) @(negedge clk);
        br_go   = 1'b1;
        br_addr = 17'h50;
        ab      = ack_addr.size();
        @(negedge clk);
        br_go = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_acks", ack_addr.size() - ab, 2);
        check("t4_ack0", ack_addr[ab], 17'h50);
        check("t4_ack1", ack_addr[ab+1], 17'h54);
        check("t4_req", mem_req, 1'b0);
        check("t4_data", data, 8'h50);
        check("t4_pc", pc, 17'h50);
        p_inc = 1'b1;
        repeat (3) @(negedge clk);
        p_inc = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_acks_free3", ack_addr.size() - ab, 2);
        check("t4_data3", data, 8'h53);
        check("t4_pc3", pc, 17'h53);
        p_inc = 1'b1;
        @(negedge clk);
        p_inc = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_acks_free4", ack_addr.size() - ab, 3);
        check("t4_ack2", ack_addr[ab+2], 17'h58);

        // Empty FIFO with p_inc held: nop presented, pc holds
        repeat (4) @(negedge clk);
        mem_auto = 1'b0;
        br_go    = 1'b1;
        br_addr  = 17'h61;
        p_inc    = 1'b1;
        @(negedge clk);
        br_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_data", data, 8'h00);
            check("t5_vld", data_vld, 1'b0);
            check("t5_pc", pc, 17'h61);
        end
        check("t5_req", mem_req, 1'b1);
        check("t5_addr", mem_addr, 17'h60);

        // Reset during an outstanding request; late ack after release
        rst = 1'b0;
        #1;
        check("t6_pc", pc, 17'h10);
        check("t6_req", mem_req, 1'b0);
        check("t6_addr", mem_addr, 17'h0);
        check("t6_data", data, 8'h00);
        check("t6_vld", data_vld, 1'b0);
        @(posedge clk);
        inject_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        pb  = pop_data.size();
        ab  = ack_addr.size();
        #2;
        inject_ack = 1'b0;
        mem_auto   = 1'b1;
        wait_pops(pb, 4, "t6");
        for (int k = 0; k < 4; k++) begin
            check("t6_rdata", pop_data[pb+k], 8'(8'h11 * (k + 1)));
            check("t6_rpc", pop_pc[pb+k], 17'h10 + k);
        end
        check("t6_ack0", ack_addr[ab], 17'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
